// File: rtl/dense_neuron_seq.sv
// ---------------------------------------------------------------------------
// dense_neuron_seq
//   Sequencer and post-processing stage wrapped around one external Q8.8
//   dense-layer MAC cell. It accepts a stream of (x, w) pairs for one neuron
//   and registers them into the MAC operand ports. The running sum is fed back
//   through the MAC sum port, and the MAC result is accumulated. When the
//   stream is done, the neuron bias is added with saturation, an optional ReLU
//   is applied, and one result per neuron is emitted.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. A producer holds valid and its data stable
//   until that transfer. ready never depends combinationally on valid.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_i           begin a neuron; sampled only in IDLE
//   len_i, bias_i     pair count and Q8.8 bias, latched on start
//   in_valid_i/in_ready_o, in_x_i, in_w_i   upstream (x, w) pair stream
//   mac_input_o, mac_w_o                    registered MAC operands
//   mac_sum_o                               accumulator, fed back to the MAC
//   mac_output_i                            MAC result (sum + registered product)
//   out_valid_o/out_ready_i, out_data_o     downstream neuron result
//   busy_o            high in every state except IDLE
//   dbg_state_o       current FSM state, for observation only
//
// Parameters
//   LEN_W    width of len_i; at most 2**LEN_W-1 pairs per neuron
//   RELU_EN  1: negative results clamp to 0; 0: pass the signed result
// ---------------------------------------------------------------------------
module dense_neuron_seq #(
  parameter int LEN_W   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [15:0]      bias_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_x_i,
  input  logic [15:0]      in_w_i,
  output logic [15:0]      mac_input_o,
  output logic [15:0]      mac_w_o,
  output logic [15:0]      mac_sum_o,
  input  logic [15:0]      mac_output_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic             busy_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [15:0]        bias_q;
  logic [15:0]        acc_q;
  logic               v1_q, v2_q;
  logic [15:0]        mac_in_q, mac_w_q;
  logic               out_valid_q;
  logic [15:0]        out_data_q;

  logic               in_ready;
  logic               in_hs;
  logic               start_hs;
  logic signed [16:0] sum_s;
  logic [15:0]        post_res;

  assign start_hs = (state_q == S_IDLE) && start_i;
  assign in_hs    = in_valid_i && in_ready;

  // ---------------- FSM: next state and handshake outputs ----------------
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? S_DRAIN : S_ACC;
        end
      end
      S_ACC: begin
        in_ready = (cnt_q < len_q);
        // Leave on the accept of the last pair, so ready is already low in
        // the cycle where cnt reaches len.
        if (in_valid_i && in_ready && (cnt_q == len_q - 1'b1)) begin
          state_d = S_DRAIN;
        end else if (cnt_q >= len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once v1 is low, no new product can arrive. Any pending v2 commits
        // into acc at this edge, so BIAS sees the final sum with v1=v2=0.
        if (!v1_q) begin
          state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- bias add with saturation, optional ReLU ----------------
  assign sum_s = {acc_q[15], acc_q} + {bias_q[15], bias_q};

  always_comb begin
    post_res = sum_s[15:0];
    if (sum_s > 17'sd32767) begin
      post_res = 16'h7FFF;
    end else if (sum_s < -17'sd32768) begin
      post_res = 16'h8000;
    end
    if (RELU_EN && post_res[15]) begin
      post_res = 16'h0000;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      bias_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      mac_in_q    <= '0;
      mac_w_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // Operand stage: zero operands and a cleared v1 on every non-accept
      // cycle, so bubbles feed nothing into the MAC.
      if (in_hs) begin
        mac_in_q <= in_x_i;
        mac_w_q  <= in_w_i;
        v1_q     <= 1'b1;
        cnt_q    <= cnt_q + 1'b1;
      end else begin
        mac_in_q <= '0;
        mac_w_q  <= '0;
        v1_q     <= 1'b0;
      end

      // v2 marks the cycle where mac_output_i carries a product that belongs
      // to this neuron. Without it, acc would pick up stale MAC contents.
      v2_q <= v1_q;

      if (start_hs) begin
        len_q  <= len_i;
        bias_q <= bias_i;
        cnt_q  <= '0;
        acc_q  <= '0;
      end else if (v2_q) begin
        acc_q <= mac_output_i;
      end

      if (state_q == S_BIAS) begin
        out_data_q  <= post_res;
        out_valid_q <= 1'b1;
      end else if ((state_q == S_OUT) && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign mac_input_o = mac_in_q;
  assign mac_w_o     = mac_w_q;
  assign mac_sum_o   = acc_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dense_neuron_seq.sv
// ---------------------------------------------------------------------------
// tb_dense_neuron_seq
//   Two copies of dense_neuron_seq (RELU_EN=1 and RELU_EN=0) share one input
//   stream. Each copy has its own model of the Q8.8 MAC cell. The model
//   registers the truncated product of the operands and adds it to the sum
//   port combinationally. Its product register is not reset and powers up
//   with junk, so it behaves like the real buffer.
//   Expected results come from a per-neuron arithmetic model that works on
//   the list of pairs directly.
// ---------------------------------------------------------------------------
module tb_dense_neuron_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start_i = 1'b0;
  logic [7:0]  len_i = '0;
  logic [15:0] bias_i = '0;
  logic        in_valid_i = 1'b0;
  logic [15:0] in_x_i = '0;
  logic [15:0] in_w_i = '0;
  logic        out_ready_i = 1'b0;

  // ---------------- DUT A: RELU_EN=1 ----------------
  logic        in_ready_a, out_valid_a, busy_a;
  logic [15:0] mac_input_a, mac_w_a, mac_sum_a, mac_out_a, out_data_a;
  logic [2:0]  dbg_state_a;
  logic [15:0] prod_a = 16'h5A5A;

  dense_neuron_seq #(.LEN_W(8), .RELU_EN(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .bias_i(bias_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_a), .in_x_i(in_x_i), .in_w_i(in_w_i),
    .mac_input_o(mac_input_a), .mac_w_o(mac_w_a), .mac_sum_o(mac_sum_a),
    .mac_output_i(mac_out_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready_i),
    .out_data_o(out_data_a), .busy_o(busy_a), .dbg_state_o(dbg_state_a)
  );

  // ---------------- DUT B: RELU_EN=0 ----------------
  logic        in_ready_b, out_valid_b, busy_b;
  logic [15:0] mac_input_b, mac_w_b, mac_sum_b, mac_out_b, out_data_b;
  logic [2:0]  dbg_state_b;
  logic [15:0] prod_b = 16'hA5A5;

  dense_neuron_seq #(.LEN_W(8), .RELU_EN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .bias_i(bias_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_b), .in_x_i(in_x_i), .in_w_i(in_w_i),
    .mac_input_o(mac_input_b), .mac_w_o(mac_w_b), .mac_sum_o(mac_sum_b),
    .mac_output_i(mac_out_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready_i),
    .out_data_o(out_data_b), .busy_o(busy_b), .dbg_state_o(dbg_state_b)
  );

  // ---------------- MAC cell models ----------------
  function automatic logic [15:0] q_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] pr;
    pr = $signed(a) * $signed(b);
    return pr[23:8];
  endfunction

  always @(posedge clk) prod_a <= q_mul(mac_input_a, mac_w_a);
  always @(posedge clk) prod_b <= q_mul(mac_input_b, mac_w_b);
  assign mac_out_a = mac_sum_a + prod_a;
  assign mac_out_b = mac_sum_b + prod_b;

  // ---------------- reference model and scoreboard ----------------
  logic [15:0] px [0:15];
  logic [15:0] pw [0:15];
  logic [15:0] exp_q[$];
  logic [15:0] exp_nr_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [15:0] ref_neuron(input int len, input logic [15:0] b, input bit relu);
    logic [15:0] acc;
    int p;
    int s;
    acc = 16'h0000;
    for (int i = 0; i < len; i++) begin
      p = (int'($signed(px[i])) * int'($signed(pw[i]))) >>> 8;
      acc = acc + 16'(p);
    end
    s = int'($signed(acc)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic push_expected(input int len, input logic [15:0] b);
    exp_q.push_back(ref_neuron(len, b, 1'b1));
    exp_nr_q.push_back(ref_neuron(len, b, 1'b0));
  endtask

  // ---------------- driver ----------------
  // Runs one neuron from px/pw. lat counts edges from the last accept (or
  // from the start when len=0), including that edge, until out_valid is seen.
  task automatic do_neuron(input int len, input logic [15:0] b, input int max_bub,
                           input bit release_out, output logic [15:0] got_a,
                           output logic [15:0] got_b, output bit vb, output int lat,
                           output bit tmo);
    int guard;
    tmo = 1'b0;
    start_i = 1'b1; len_i = 8'(len); bias_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; len_i = 8'($urandom); bias_i = 16'($urandom);
    lat = 1;
    for (int k = 0; k < len; k++) begin
      if (max_bub > 0) begin
        repeat ($urandom_range(0, max_bub)) begin
          in_valid_i = 1'b0; in_x_i = 16'($urandom); in_w_i = 16'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid_i = 1'b1; in_x_i = px[k]; in_w_i = pw[k];
      guard = 0;
      while (!in_ready_a && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
      if (!in_ready_a) tmo = 1'b1;
      @(posedge clk); #1;
      lat = 1;
    end
    in_valid_i = 1'b0; in_x_i = 16'($urandom); in_w_i = 16'($urandom);
    while (!out_valid_a && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid_a) tmo = 1'b1;
    got_a = out_data_a; got_b = out_data_b; vb = out_valid_b;
    if (release_out) begin
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({in_ready_a, out_valid_a, busy_a, mac_input_a, mac_w_a, mac_sum_a, out_data_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got ir=%b ov=%b busy=%b mi=%h mw=%h ms=%h od=%h, required all 0",
               in_ready_a, out_valid_a, busy_a, mac_input_a, mac_w_a, mac_sum_a, out_data_a);
    end
    n_checks++;
    if ({in_ready_b, out_valid_b, busy_b, out_data_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got ir=%b ov=%b busy=%b od=%h, required all 0",
               in_ready_b, out_valid_b, busy_b, out_data_b);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b ov=%b, required 0 0", busy_a, out_valid_a);
    end
  endtask

  task automatic test_single();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    px[0] = 16'h0100; pw[0] = 16'h0200;
    do_neuron(1, 16'h0080, 0, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h0280 || gb !== 16'h0280 || !vb) begin
      n_fail++;
      $display("FAIL single: got a=%h b=%h vb=%b tmo=%b, required 0280 0280 1 0", ga, gb, vb, tmo);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL single_latency: got %0d, required 4", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    px[0] = 16'h0100; pw[0] = 16'h0100;
    px[1] = 16'h0200; pw[1] = 16'h0080;
    px[2] = 16'h0080; pw[2] = 16'h0200;
    px[3] = 16'hFF00; pw[3] = 16'h0100;
    do_neuron(4, 16'h0000, 0, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h0200 || gb !== 16'h0200 || lat !== 4) begin
      n_fail++;
      $display("FAIL back_to_back: got a=%h b=%h lat=%0d tmo=%b, required 0200 0200 4 0", ga, gb, lat, tmo);
    end
    do_neuron(4, 16'h0000, 3, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h0200 || gb !== 16'h0200 || lat !== 4) begin
      n_fail++;
      $display("FAIL bubbles: got a=%h b=%h lat=%0d tmo=%b, required 0200 0200 4 0", ga, gb, lat, tmo);
    end
  endtask

  task automatic test_relu();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    px[0] = 16'h0100; pw[0] = 16'hFE00;
    do_neuron(1, 16'h0000, 0, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h0000) begin
      n_fail++;
      $display("FAIL relu_on: got %h tmo=%b, required 0000", ga, tmo);
    end
    n_checks++;
    if (gb !== 16'hFE00) begin
      n_fail++;
      $display("FAIL relu_off: got %h, required FE00", gb);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    px[0] = 16'h7F00; pw[0] = 16'h0100;
    do_neuron(1, 16'h7F00, 0, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h7FFF || gb !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL sat_pos: got a=%h b=%h tmo=%b, required 7FFF 7FFF", ga, gb, tmo);
    end
    px[0] = 16'h8000; pw[0] = 16'h0100;
    do_neuron(1, 16'h8000, 0, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h0000 || gb !== 16'h8000) begin
      n_fail++;
      $display("FAIL sat_neg: got a=%h b=%h tmo=%b, required 0000 8000", ga, gb, tmo);
    end
    do_neuron(0, 16'h0123, 0, 1'b1, ga, gb, vb, lat, tmo);
    n_checks++;
    if (tmo || ga !== 16'h0123 || gb !== 16'h0123 || lat !== 3) begin
      n_fail++;
      $display("FAIL len_zero: got a=%h b=%h lat=%0d tmo=%b, required 0123 0123 3 0", ga, gb, lat, tmo);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    logic [15:0] ea, eb;
    for (int i = 0; i < 2; i++) begin
      px[i] = 16'($urandom_range(0, 16'h0400)); pw[i] = 16'($urandom);
    end
    push_expected(2, 16'h0040);
    do_neuron(2, 16'h0040, 0, 1'b0, ga, gb, vb, lat, tmo);
    ea = exp_q.pop_front(); eb = exp_nr_q.pop_front();
    n_checks++;
    if (tmo || ga !== ea || gb !== eb) begin
      n_fail++;
      $display("FAIL hold_result: got a=%h b=%h tmo=%b, required %h %h", ga, gb, tmo, ea, eb);
    end
    for (int c = 0; c < 10; c++) begin
      start_i = 1'b1; len_i = 8'd5; bias_i = 16'h1111;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== ea || busy_a !== 1'b1 || out_data_b !== eb) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: ov=%b od=%h busy=%b odb=%h, required 1 %h 1 %h",
                 c, out_valid_a, out_data_a, busy_a, out_data_b, ea, eb);
      end
    end
    // Release with start still high: start in the release cycle is not taken.
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0; start_i = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: busy=%b ov=%b, required 0 0", busy_a, out_valid_a);
    end
    for (int i = 0; i < 3; i++) begin
      px[i] = 16'($urandom); pw[i] = 16'($urandom_range(0, 16'h0200));
    end
    push_expected(3, 16'hFFC0);
    do_neuron(3, 16'hFFC0, 1, 1'b1, ga, gb, vb, lat, tmo);
    ea = exp_q.pop_front(); eb = exp_nr_q.pop_front();
    n_checks++;
    if (tmo || ga !== ea || gb !== eb) begin
      n_fail++;
      $display("FAIL after_hold: got a=%h b=%h tmo=%b, required %h %h", ga, gb, tmo, ea, eb);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    logic [15:0] ea, eb;
    start_i = 1'b1; len_i = 8'd6; bias_i = 16'h0100;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1; in_x_i = 16'h0300 + 16'(k); in_w_i = 16'h0280;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    in_valid_i = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_a, out_valid_a, busy_a, mac_input_a, mac_w_a, mac_sum_a, out_data_a, busy_b} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ir=%b ov=%b busy=%b mi=%h mw=%h ms=%h od=%h, required all 0",
               in_ready_a, out_valid_a, busy_a, mac_input_a, mac_w_a, mac_sum_a, out_data_a);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      px[i] = 16'($urandom_range(0, 16'h0300)); pw[i] = 16'($urandom_range(0, 16'h0300));
    end
    push_expected(3, 16'h0000);
    do_neuron(3, 16'h0000, 0, 1'b1, ga, gb, vb, lat, tmo);
    ea = exp_q.pop_front(); eb = exp_nr_q.pop_front();
    n_checks++;
    if (tmo || ga !== ea || gb !== eb || lat !== 4) begin
      n_fail++;
      $display("FAIL after_reset: got a=%h b=%h lat=%0d tmo=%b, required %h %h 4",
               ga, gb, lat, tmo, ea, eb);
    end
  endtask

  task automatic test_random();
    logic [15:0] ga, gb; bit vb; int lat; bit tmo;
    logic [15:0] ea, eb, b;
    int len;
    for (int n = 0; n < 24; n++) begin
      len = $urandom_range(0, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          px[i] = 16'($urandom); pw[i] = 16'($urandom);
        end else begin
          px[i] = 16'($signed(16'($urandom_range(0, 16'h0600))) - 16'sh0300);
          pw[i] = 16'($signed(16'($urandom_range(0, 16'h0600))) - 16'sh0300);
        end
      end
      b = 16'($urandom);
      push_expected(len, b);
      do_neuron(len, b, $urandom_range(0, 2), 1'b1, ga, gb, vb, lat, tmo);
      ea = exp_q.pop_front(); eb = exp_nr_q.pop_front();
      n_checks++;
      if (tmo || ga !== ea || gb !== eb || !vb || lat !== ((len == 0) ? 3 : 4)) begin
        n_fail++;
        $display("FAIL random[%0d] len=%0d: got a=%h b=%h vb=%b lat=%0d tmo=%b, required %h %h 1 %0d",
                 n, len, ga, gb, vb, lat, tmo, ea, eb, (len == 0) ? 3 : 4);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_relu();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
